// File: rtl/core_run_ctrl.sv
// rtl/core_run_ctrl.sv - anneal run sequencer: phase timing, convergence check, result stream
module core_run_ctrl #(
    parameter int ARRAY_SIZE = 64,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  program_done,
    input  logic [DATA_WIDTH-1:0] weight_time_off,
    input  logic [DATA_WIDTH-1:0] rosc_time,
    input  logic [DATA_WIDTH-1:0] shil_time,
    input  logic [DATA_WIDTH-1:0] sample_delay,
    input  logic [DATA_WIDTH-1:0] sample_time,
    input  logic [DATA_WIDTH-1:0] max_fails,
    input  logic [DATA_WIDTH-1:0] problem_id,
    input  logic [ARRAY_SIZE-1:0] spin_in,
    output logic                  weight_en,
    output logic                  rosc_en,
    output logic                  shil_en,
    output logic                  sample_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  core_done,
    output logic                  busy
);

    localparam int SPIN_WORDS = ARRAY_SIZE / DATA_WIDTH;
    localparam int NUM_WORDS  = SPIN_WORDS + 2;
    localparam int IDX_W      = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_WEIGHT = 4'd1;
    localparam logic [3:0] S_ROSC   = 4'd2;
    localparam logic [3:0] S_SHIL   = 4'd3;
    localparam logic [3:0] S_DELAY  = 4'd4;
    localparam logic [3:0] S_SAMPLE = 4'd5;
    localparam logic [3:0] S_CHECK  = 4'd6;
    localparam logic [3:0] S_OUT    = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    logic [3:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] attempts_q, attempts_d;
    logic [DATA_WIDTH-1:0] mismatch_q, mismatch_d;
    logic                  fail_q, fail_d;
    logic [ARRAY_SIZE-1:0] cur_spin_q, cur_spin_d;
    logic [ARRAY_SIZE-1:0] prev_spin_q, prev_spin_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  pd_q;
    logic                  pd_low_seen_q;
    logic                  start;
    logic                  cnt_zero;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] mismatch_inc;
    logic                  unused_attempts_msb;

    // A duration of zero still occupies one cycle, so the counter holds N-1.
    function automatic logic [DATA_WIDTH-1:0] load_val(input logic [DATA_WIDTH-1:0] n);
        return (n == '0) ? '0 : n - ONE;
    endfunction

    // Only a genuine low-to-high transition launches a run; a level held across reset does not.
    assign start        = program_done && !pd_q && pd_low_seen_q;
    assign cnt_zero     = (cnt_q == '0);
    assign xfer         = m_valid && m_ready;
    assign mismatch_inc = mismatch_q + ONE;
    assign unused_attempts_msb = attempts_q[DATA_WIDTH-1];

    // Next-state, phase timing and convergence bookkeeping.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        attempts_d  = attempts_q;
        mismatch_d  = mismatch_q;
        fail_d      = fail_q;
        cur_spin_d  = cur_spin_q;
        prev_spin_d = prev_spin_q;
        idx_d       = idx_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d    = S_WEIGHT;
                cnt_d      = load_val(weight_time_off);
                attempts_d = '0;
                mismatch_d = '0;
                fail_d     = 1'b0;
            end
            S_WEIGHT: if (cnt_zero) begin
                state_d = S_ROSC;
                cnt_d   = load_val(rosc_time);
            end else cnt_d = cnt_q - ONE;
            S_ROSC: if (cnt_zero) begin
                state_d = S_SHIL;
                cnt_d   = load_val(shil_time);
            end else cnt_d = cnt_q - ONE;
            S_SHIL: if (cnt_zero) begin
                state_d = S_DELAY;
                cnt_d   = load_val(sample_delay);
            end else cnt_d = cnt_q - ONE;
            S_DELAY: if (cnt_zero) begin
                state_d = S_SAMPLE;
                cnt_d   = load_val(sample_time);
            end else cnt_d = cnt_q - ONE;
            S_SAMPLE: if (cnt_zero) begin
                state_d    = S_CHECK;
                cur_spin_d = spin_in;
            end else cnt_d = cnt_q - ONE;
            S_CHECK: begin
                attempts_d = attempts_q + ONE;
                if (max_fails == '0) begin
                    state_d = S_OUT;
                    idx_d   = '0;
                end else if (attempts_q == '0) begin
                    // First sample only seeds the comparison; retry skips WEIGHT.
                    prev_spin_d = cur_spin_q;
                    state_d     = S_ROSC;
                    cnt_d       = load_val(rosc_time);
                end else if (cur_spin_q == prev_spin_q) begin
                    state_d = S_OUT;
                    idx_d   = '0;
                end else begin
                    mismatch_d  = mismatch_inc;
                    prev_spin_d = cur_spin_q;
                    if (mismatch_inc == max_fails) begin
                        fail_d  = 1'b1;
                        state_d = S_OUT;
                        idx_d   = '0;
                    end else begin
                        state_d = S_ROSC;
                        cnt_d   = load_val(rosc_time);
                    end
                end
            end
            S_OUT: if (xfer) begin
                if (idx_q == LAST_IDX) state_d = S_DONE;
                else idx_d = idx_q + IDX_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            attempts_q    <= '0;
            mismatch_q    <= '0;
            fail_q        <= 1'b0;
            cur_spin_q    <= '0;
            prev_spin_q   <= '0;
            idx_q         <= '0;
            pd_q          <= 1'b0;
            pd_low_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            attempts_q  <= attempts_d;
            mismatch_q  <= mismatch_d;
            fail_q      <= fail_d;
            cur_spin_q  <= cur_spin_d;
            prev_spin_q <= prev_spin_d;
            idx_q       <= idx_d;
            pd_q        <= program_done;
            if (!program_done) pd_low_seen_q <= 1'b1;
        end
    end

    // Enables and stream controls decode straight from the state register.
    always_comb begin
        busy      = (state_q != S_IDLE);
        weight_en = (state_q >= S_WEIGHT) && (state_q <= S_SAMPLE);
        rosc_en   = (state_q >= S_ROSC) && (state_q <= S_SAMPLE);
        shil_en   = (state_q >= S_SHIL) && (state_q <= S_SAMPLE);
        sample_en = (state_q == S_SAMPLE);
        m_valid   = (state_q == S_OUT);
        m_last    = (state_q == S_OUT) && (idx_q == LAST_IDX);
        core_done = (state_q == S_DONE);
    end

    // Output word select: id, spin words low first, then status.
    always_comb begin
        m_data = '0;
        if (state_q == S_OUT) begin
            if (idx_q == '0) begin
                m_data = problem_id;
            end else if (idx_q == LAST_IDX) begin
                m_data = {fail_q, attempts_q[DATA_WIDTH-2:0]};
            end else begin
                for (int k = 0; k < SPIN_WORDS; k++) begin
                    if (idx_q == IDX_W'(k + 1)) m_data = cur_spin_q[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Sequencer that runs one anneal of the oscillator core once the AXI loader has finished programming it. It steps through weight settle, free-run, SHIL lock, sample delay and sample phases, timed by the loader's control words. It repeats anneals until two consecutive spin samples agree or a fail budget runs out, then streams the result out. It finishes by pulsing `core_done` back to the loader.

## Interface
- `ARRAY_SIZE`, 64, spin count; an integer multiple of `DATA_WIDTH`.
- `DATA_WIDTH`, 32, width of the control words and of the output stream.
- `clk` in 1: single clock.
- `resetb` in 1: asynchronous, active-low reset.
- `program_done` in 1: loader done flag; held high until `core_done`.
- `weight_time_off`, `rosc_time`, `shil_time`, `sample_delay`, `sample_time`, `max_fails`, `problem_id` in `DATA_WIDTH` each: loader control words, stable while `program_done` is high.
- `spin_in` in `ARRAY_SIZE`: core spin readout, valid during SAMPLE.
- `weight_en`, `rosc_en`, `shil_en`, `sample_en` out 1 each: core phase enables (registered).
- `m_valid` out 1, `m_ready` in 1, `m_last` out 1, `m_data` out `DATA_WIDTH`: result stream.
- `core_done` out 1: one-cycle pulse; run complete.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States, in order: IDLE, WEIGHT, ROSC, SHIL, DELAY, SAMPLE, CHECK, OUT, DONE.
- Start condition: a rising edge of `program_done`, detected with a registered copy of `program_done`. A level that stays high does not restart the run. This prevents re-launch in the cycle after `core_done`, while the loader still holds `program_done` high.
- Phase durations:
  - A timed phase with duration N lasts exactly N cycles; N=0 is treated as 1.
  - The down-counter is `DATA_WIDTH` bits, loaded with N-1 on phase entry.
  - The phase exits when the counter equals 0.
- Phase enables:
  - WEIGHT (`weight_time_off`): `weight_en`=1.
  - ROSC (`rosc_time`): `weight_en`=1, `rosc_en`=1.
  - SHIL (`shil_time`): `weight_en`, `rosc_en`, `shil_en` all 1.
  - DELAY (`sample_delay`): `weight_en`, `rosc_en`, `shil_en` all 1.
  - SAMPLE (`sample_time`): `weight_en`, `shil_en`, `sample_en` all 1; `rosc_en`=1.
  - On the last SAMPLE cycle, `spin_in` is captured into `cur_spin`.
- CHECK (1 cycle); `attempts` is incremented on every entry:
  - If `max_fails`==0: pass immediately.
  - Else, on attempt 1: `prev_spin`<=`cur_spin`, go to ROSC.
  - Else, if `cur_spin`==`prev_spin`: pass.
  - Else: `mismatch`++ and `prev_spin`<=`cur_spin`. If the new `mismatch`==`max_fails`, set `fail`=1 and go to OUT; otherwise go to ROSC.
  - A retry skips WEIGHT, since the weights stay applied.
- OUT: emits `ARRAY_SIZE`/`DATA_WIDTH`+2 words in this order:
  - Word 0: `problem_id`.
  - Next words: `cur_spin`, least-significant `DATA_WIDTH` bits first.
  - Final word: {`fail`, `attempts`[`DATA_WIDTH`-2:0]}, with `m_last`=1.
- OUT handshake:
  - `m_data`, `m_last` and `m_valid` hold until `m_valid`&&`m_ready`.
  - `m_valid` never drops without a transfer.
  - `m_ready` is ignored outside OUT.
- DONE: `core_done`=1 for exactly one cycle, then IDLE. `attempts`, `mismatch` and `fail` clear on IDLE→WEIGHT.
- Counters: `attempts` and `mismatch` are `DATA_WIDTH` bits. They cannot wrap, because `mismatch` ≤ `max_fails`.
- Reset, asynchronous, any state: state=IDLE.
  - All outputs 0: `weight_en`, `rosc_en`, `shil_en`, `sample_en`, `m_valid`, `m_last`, `m_data`, `core_done`, `busy`.
  - Spin registers, counters, `fail` and the `program_done` edge register all clear to 0.
  - If `program_done` is already high when reset releases, no run starts until a new rising edge arrives.

## Timing
- Rising `program_done` sampled at edge t: state=WEIGHT and `weight_en`=1 from t+1.
- All enables are decoded from registered state and change on the same edge as the state.
- Run length with no retries:
  - Phase time = max(w,1)+max(r,1)+max(s,1)+max(d,1)+max(p,1) cycles.
  - Plus 1 CHECK cycle, plus the OUT cycles, plus 1 DONE cycle.
- Each retry adds max(r,1)+max(s,1)+max(d,1)+max(p,1)+1 cycles.
- OUT: the first `m_valid` appears in the cycle after CHECK. With `m_ready` tied high, one word transfers per cycle. `core_done` rises in the cycle after the `m_last` transfer.

## Test plan
- Basic run:
  - Stimulus: `ARRAY_SIZE`=64, w=r=s=d=p=2, `max_fails`=0, `problem_id`=0xA5, `spin_in` constant, `m_ready`=1.
  - Required: each phase lasts 2 cycles with the enables given above.
  - Required: 4 words out: 0xA5, spin[31:0], spin[63:32], 0x00000001 with `m_last`=1.
  - Required: `core_done` pulses exactly once.
- Zero durations:
  - Stimulus: all durations 0.
  - Required: every phase lasts exactly 1 cycle; total from edge to `core_done` matches the formula above.
- Convergence:
  - Stimulus: `max_fails`=3; samples A, B, B.
  - Required: 3 attempts, pass; status word 0x00000003; spin words = B.
- Fail budget:
  - Stimulus: `max_fails`=2; samples A, B, C.
  - Required: after attempt 3, status word 0x80000003 with `fail`=1; spin words = C; ROSC is entered 3 times and WEIGHT once.
- Backpressure:
  - Stimulus: toggle `m_ready` randomly during OUT.
  - Required: `m_data` and `m_last` stable while `m_valid`&&!`m_ready`; no word lost or duplicated; `core_done` only after the last word transfers.
- Reset and re-arm:
  - Stimulus: assert `resetb`=0 during SHIL, then release with `program_done` held high.
  - Required: all outputs 0 immediately and no restart after release. Dropping `program_done` and raising it again starts a fresh run.
  - Stimulus: hold `program_done` high for 3 cycles after `core_done`.
  - Required: no second run.
